// File: rtl/mips_cpu_mult_div_if.sv
// Request/result bundle between the CPU pipeline and the HI/LO multiply-divide unit.
// master = pipeline side, slave = multiply-divide unit.
interface mips_cpu_mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, operand_a, operand_b, write_hi, write_lo, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, write_hi, write_lo, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, 1 bit per cycle.
// Latency: start at E0 -> hi/lo/done valid after E33.
// Backpressure: start, MTHI and MTLO are dropped while busy; no queueing.
module mips_cpu_mult_div (
    input logic                   clk,
    input logic                   reset,
    mips_cpu_mult_div_if.slave    md
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state, state_nxt;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        b_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Operand conditioning for the accept edge.
    logic        sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        sgn   = ~md.op[0];
        a_neg = sgn & md.operand_a[31];
        b_neg = sgn & md.operand_b[31];
        a_mag = a_neg ? (32'd0 - md.operand_a) : md.operand_a;
        b_mag = b_neg ? (32'd0 - md.operand_b) : md.operand_b;
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = acc[63:31];
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[32];
        if (is_div)
            acc_step = {(div_ok ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ok};
        else
            acc_step = {mul_sum, acc[31:1]};
    end

    // Sign correction; divide-by-zero leaves remainder = dividend, so only lo is forced.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

    always_comb begin
        prod_fix = neg_res ? (64'd0 - acc) : acc;
        quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
        if (is_div) begin
            fin_hi = rem_fix;
            fin_lo = b_zero ? 32'hFFFF_FFFF : quo_fix;
        end else begin
            fin_hi = prod_fix[63:32];
            fin_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (md.start) state_nxt = RUN;
            RUN:     if (count == 6'd31) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 6'd0;
            acc     <= 64'd0;
            opnd    <= 32'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == FIN);
            case (state)
                IDLE: begin
                    if (md.start) begin
                        count   <= 6'd0;
                        is_div  <= md.op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= md.op[1] & a_neg;
                        b_zero  <= (md.operand_b == 32'd0);
                        if (md.op[1]) begin
                            acc  <= {32'd0, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {32'd0, b_mag};
                            opnd <= a_mag;
                        end
                    end else begin
                        if (md.write_hi) hi_q <= md.write_data;
                        if (md.write_lo) lo_q <= md.write_data;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 6'd1;
                end
                FIN: begin
                    hi_q <= fin_hi;
                    lo_q <= fin_lo;
                end
                default: ;
            endcase
        end
    end

    assign md.busy = (state != IDLE);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Directed-vector bench for mips_cpu_mult_div: arithmetic results, latency,
// MTHI/MTLO behaviour and reset priority.
module tb_mips_cpu_mult_div;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mips_cpu_mult_div_if bus();

    mips_cpu_mult_div dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one active edge, then settle before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.op         = 2'b00;
        bus.operand_a  = 32'd0;
        bus.operand_b  = 32'd0;
        bus.write_hi   = 1'b0;
        bus.write_lo   = 1'b0;
        bus.write_data = 32'd0;
    endtask

    // Full operation: E0 accept, E1..E32 iterate, E33 writes hi/lo and raises done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int pulses;
        int busy_low;
        pulses   = 0;
        busy_low = 0;
        bus.start     = 1'b1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        tick();
        bus.start     = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
        bus.op        = ~o;
        chk({tag, "_busy_e0"}, {63'd0, bus.busy}, 64'd1);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (bus.done) pulses++;
            if (!bus.busy) busy_low++;
        end
        chk({tag, "_early_done"}, pulses, 64'd0);
        chk({tag, "_busy_run"}, busy_low, 64'd0);
        tick();
        chk({tag, "_done_e33"}, {63'd0, bus.done}, 64'd1);
        chk({tag, "_idle_e33"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        tick();
        chk({tag, "_done_once"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int pulses;
        int busy_hi;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);

        // Start on the very first edge after reset release.
        reset = 1'b0;
        run_op("mult_m3x7",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7d2",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2",   2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_100d7", 2'b11, 32'd100,      32'd7,        32'd2,         32'd14);
        run_op("divu_by0",   2'b11, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_m5by0",  2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTHI and MTLO together in IDLE.
        bus.write_hi   = 1'b1;
        bus.write_lo   = 1'b1;
        bus.write_data = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        chk("mt_both_hi", {32'd0, bus.hi}, 64'h0000_0000_CAFE_F00D);
        chk("mt_both_lo", {32'd0, bus.lo}, 64'h0000_0000_CAFE_F00D);
        chk("mt_both_done", {63'd0, bus.done}, 64'd0);

        // MTHI alone leaves lo.
        bus.write_hi   = 1'b1;
        bus.write_data = 32'h1111_2222;
        tick();
        idle_inputs();
        chk("mthi_hi", {32'd0, bus.hi}, 64'h0000_0000_1111_2222);
        chk("mthi_lo", {32'd0, bus.lo}, 64'h0000_0000_CAFE_F00D);

        // Start wins over same-cycle writes; writes while busy are dropped.
        bus.start      = 1'b1;
        bus.op         = 2'b01;
        bus.operand_a  = 32'd2;
        bus.operand_b  = 32'd3;
        bus.write_hi   = 1'b1;
        bus.write_lo   = 1'b1;
        bus.write_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk("sw_busy", {63'd0, bus.busy}, 64'd1);
        chk("sw_hi_kept", {32'd0, bus.hi}, 64'h0000_0000_1111_2222);
        chk("sw_lo_kept", {32'd0, bus.lo}, 64'h0000_0000_CAFE_F00D);
        for (int i = 1; i < 16; i++) tick();
        bus.write_hi   = 1'b1;
        bus.write_lo   = 1'b1;
        bus.write_data = 32'h5555_AAAA;
        tick();
        idle_inputs();
        chk("busy_wr_hi", {32'd0, bus.hi}, 64'h0000_0000_1111_2222);
        chk("busy_wr_lo", {32'd0, bus.lo}, 64'h0000_0000_CAFE_F00D);
        for (int i = 17; i <= 33; i++) tick();
        chk("sw_done", {63'd0, bus.done}, 64'd1);
        chk("sw_res_hi", {32'd0, bus.hi}, 64'd0);
        chk("sw_res_lo", {32'd0, bus.lo}, 64'd6);
        tick();

        // Mid-run restart attempt at E10, reset together with start/writes at E20.
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd6;
        tick();
        idle_inputs();
        for (int i = 1; i < 10; i++) tick();
        bus.start      = 1'b1;
        bus.op         = 2'b11;
        bus.operand_a  = 32'd9;
        bus.operand_b  = 32'd3;
        bus.write_lo   = 1'b1;
        bus.write_data = 32'h7777_7777;
        tick();
        idle_inputs();
        chk("e10_busy", {63'd0, bus.busy}, 64'd1);
        chk("e10_lo_kept", {32'd0, bus.lo}, 64'd6);
        for (int i = 11; i < 20; i++) tick();
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.write_hi   = 1'b1;
        bus.write_lo   = 1'b1;
        bus.write_data = 32'h9999_9999;
        tick();
        chk("e20_busy", {63'd0, bus.busy}, 64'd0);
        chk("e20_done", {63'd0, bus.done}, 64'd0);
        chk("e20_hi", {32'd0, bus.hi}, 64'd0);
        chk("e20_lo", {32'd0, bus.lo}, 64'd0);
        reset = 1'b0;
        idle_inputs();
        pulses  = 0;
        busy_hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) pulses++;
            if (bus.busy) busy_hi++;
        end
        chk("post_rst_done", pulses, 64'd0);
        chk("post_rst_busy", busy_hi, 64'd0);
        chk("post_rst_lo", {32'd0, bus.lo}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
